// File: rtl/rf_pkg.sv
// Shared regfile constants, write-mode encoding and mode normalisation.
package rf_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    WM_NONE = 3'b000,
    WM_WORD = 3'b001,
    WM_LH   = 3'b010,
    WM_LB   = 3'b011,
    WM_LHU  = 3'b110,
    WM_LBU  = 3'b111
  } wmode_e;

  // Unlisted codes (100, 101) collapse to "no write".
  function automatic wmode_e norm_mode(input logic [2:0] m);
    case (m)
      3'b001:  return WM_WORD;
      3'b010:  return WM_LH;
      3'b011:  return WM_LB;
      3'b110:  return WM_LHU;
      3'b111:  return WM_LBU;
      default: return WM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination bit per register for in-flight long-unit ops.
// Register 0 is never marked pending. A set and a clear of the same
// index in one cycle leaves the bit set.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       set_en,
  input  logic [ADDR_WIDTH-1:0]      set_idx,
  input  logic                       clr_en,
  input  logic [ADDR_WIDTH-1:0]      clr_idx,
  input  logic [ADDR_WIDTH-1:0]      rs1_idx,
  input  logic [ADDR_WIDTH-1:0]      rs2_idx,
  input  logic [ADDR_WIDTH-1:0]      rd_idx,
  output logic                       rs1_hit,
  output logic                       rs2_hit,
  output logic                       rd_hit,
  output logic [(1<<ADDR_WIDTH)-1:0] pending
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] x0_keep;

  assign x0_keep = ~{{(NUM_REGS-1){1'b0}}, 1'b1};

  // Decode set/clear requests into one-hot masks.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_idx != '0)) set_mask[set_idx] = 1'b1;
    if (clr_en)                     clr_mask[clr_idx] = 1'b1;
  end

  // Clear first, then OR in the set so a same-index set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= ((pend_q & ~clr_mask) | set_mask) & x0_keep;
  end

  assign rs1_hit = pend_q[rs1_idx];
  assign rs2_hit = pend_q[rs2_idx];
  assign rd_hit  = pend_q[rd_idx];
  assign pending = pend_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: the writeback stage always wins, a single
// buffered long-unit result drains into idle slots, a scoreboard stalls
// decode on hazards against in-flight long-unit destinations, and a
// result that waits too long requests a pipeline bubble.
module wb_port_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH   = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = RF_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [2:0]            wb_mode,
  input  logic                  lu_issue_valid,
  input  logic [ADDR_WIDTH-1:0] lu_issue_rd,
  input  logic                  lu_res_valid,
  input  logic [ADDR_WIDTH-1:0] lu_res_rd,
  input  logic [DATA_WIDTH-1:0] lu_res_data,
  input  logic [2:0]            lu_res_mode,
  output logic                  lu_res_ready,
  input  logic [ADDR_WIDTH-1:0] dec_rs1,
  input  logic [ADDR_WIDTH-1:0] dec_rs2,
  input  logic [ADDR_WIDTH-1:0] dec_rd,
  output logic                  dec_stall,
  output logic                  force_bubble,
  output logic [2:0]            rf_we3,
  output logic [DATA_WIDTH-1:0] rf_wd3,
  output logic [ADDR_WIDTH-1:0] rf_a3
);

  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

  wmode_e                wb_m;
  logic                  wb_sel;
  logic                  drain;
  logic                  accept;

  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_rd;
  logic [DATA_WIDTH-1:0] buf_data;
  wmode_e                buf_mode;

  logic [CNT_WIDTH-1:0]  starve_cnt;
  logic [CNT_WIDTH-1:0]  starve_nxt;

  logic                  rs1_hit;
  logic                  rs2_hit;
  logic                  rd_hit;
  logic [(1<<ADDR_WIDTH)-1:0] pending;

  assign wb_m         = norm_mode(wb_mode);
  assign wb_sel       = wb_valid && (wb_m != WM_NONE);
  assign drain        = buf_valid && !wb_sel;
  assign lu_res_ready = !buf_valid || drain;
  assign accept       = lu_res_valid && lu_res_ready;

  // Write-port mux: pipeline first, then buffer drain; rd 0 still takes the slot.
  always_comb begin
    rf_we3 = WM_NONE;
    rf_wd3 = '0;
    rf_a3  = '0;
    if (wb_sel) begin
      rf_a3  = wb_rd;
      rf_wd3 = wb_data;
      rf_we3 = (wb_rd != '0) ? wb_m : WM_NONE;
    end else if (buf_valid) begin
      rf_a3  = buf_rd;
      rf_wd3 = buf_data;
      rf_we3 = (buf_rd != '0) ? buf_mode : WM_NONE;
    end
  end

  // One-entry result buffer; an accept in a drain cycle refills it directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
      buf_mode  <= WM_NONE;
    end else if (accept) begin
      buf_valid <= 1'b1;
      buf_rd    <= lu_res_rd;
      buf_data  <= lu_res_data;
      buf_mode  <= norm_mode(lu_res_mode);
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

  // Count blocked cycles of a buffered result, saturating at the limit.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!buf_valid || drain)        starve_nxt = '0;
    else if (starve_cnt != STARVE_MAX) starve_nxt = starve_cnt + CNT_WIDTH'(1);
  end

  // Starvation counter and registered bubble request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt   <= '0;
      force_bubble <= 1'b0;
    end else begin
      starve_cnt   <= starve_nxt;
      force_bubble <= (starve_nxt == STARVE_MAX);
    end
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (lu_issue_valid),
    .set_idx (lu_issue_rd),
    .clr_en  (drain),
    .clr_idx (buf_rd),
    .rs1_idx (dec_rs1),
    .rs2_idx (dec_rs2),
    .rd_idx  (dec_rd),
    .rs1_hit (rs1_hit),
    .rs2_hit (rs2_hit),
    .rd_hit  (rd_hit),
    .pending (pending)
  );

  assign dec_stall = rs1_hit | rs2_hit | rd_hit;

  // Decode must never issue onto a destination that is still in flight,
  // unless that destination is being drained in the same cycle.
  issue_to_pending_a: assert property (@(posedge clk) disable iff (!rst_n)
    (lu_issue_valid && (lu_issue_rd != '0)) |->
      (!pending[lu_issue_rd] || (drain && (buf_rd == lu_issue_rd))));

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  wb_mode;
  logic        lu_issue_valid;
  logic [4:0]  lu_issue_rd;
  logic        lu_res_valid;
  logic [4:0]  lu_res_rd;
  logic [31:0] lu_res_data;
  logic [2:0]  lu_res_mode;
  logic        lu_res_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_stall;
  logic        force_bubble;
  logic [2:0]  rf_we3;
  logic [31:0] rf_wd3;
  logic [4:0]  rf_a3;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (5),
    .STARVE_LIMIT (8),
    .CNT_WIDTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_mode        (wb_mode),
    .lu_issue_valid (lu_issue_valid),
    .lu_issue_rd    (lu_issue_rd),
    .lu_res_valid   (lu_res_valid),
    .lu_res_rd      (lu_res_rd),
    .lu_res_data    (lu_res_data),
    .lu_res_mode    (lu_res_mode),
    .lu_res_ready   (lu_res_ready),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .dec_stall      (dec_stall),
    .force_bubble   (force_bubble),
    .rf_we3         (rf_we3),
    .rf_wd3         (rf_wd3),
    .rf_a3          (rf_a3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    wb_valid = 0; wb_rd = 0; wb_data = 0; wb_mode = 0;
    lu_issue_valid = 0; lu_issue_rd = 0;
    lu_res_valid = 0; lu_res_rd = 0; lu_res_data = 0; lu_res_mode = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; lu_res_valid = 1; lu_res_rd = 5; lu_res_data = 32'h1234; lu_res_mode = 3'b001;
    #1;
    checks++; if (lu_res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", lu_res_ready); end
    checks++; if (rf_we3 !== 3'b000) begin errors++; $display("FAIL reset_we got=%b exp=000", rf_we3); end
    checks++; if (dec_stall !== 1'b0 || force_bubble !== 1'b0) begin errors++; $display("FAIL reset_stall_bubble got=%b%b exp=00", dec_stall, force_bubble); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if (lu_res_ready !== 1'b1) begin errors++; $display("FAIL accept_ready got=%b exp=1", lu_res_ready); end
    @(negedge clk);
    lu_res_valid = 0;
    #1;
    checks++; if (rf_we3 !== 3'b001 || rf_a3 !== 5'd5 || rf_wd3 !== 32'h1234) begin errors++; $display("FAIL first_drain got=%b/%0d/%h exp=001/5/1234", rf_we3, rf_a3, rf_wd3); end
    @(negedge clk);
    #1;
    checks++; if (rf_we3 !== 3'b000) begin errors++; $display("FAIL after_drain_we got=%b exp=000", rf_we3); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle_inputs();
    lu_issue_valid = 1; lu_issue_rd = 7;
    @(negedge clk);
    lu_issue_valid = 0; dec_rs2 = 7;
    #1;
    checks++; if (dec_stall !== 1'b1) begin errors++; $display("FAIL stall_rs2 got=%b exp=1", dec_stall); end
    lu_res_valid = 1; lu_res_rd = 7; lu_res_data = 32'hAAAA; lu_res_mode = 3'b001;
    @(negedge clk);
    lu_res_valid = 0;
    #1;
    checks++; if (rf_we3 !== 3'b001 || rf_a3 !== 5'd7) begin errors++; $display("FAIL drain_rd7 got=%b/%0d exp=001/7", rf_we3, rf_a3); end
    checks++; if (dec_stall !== 1'b1) begin errors++; $display("FAIL stall_during_drain got=%b exp=1", dec_stall); end
    @(negedge clk);
    #1;
    checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL stall_cleared got=%b exp=0", dec_stall); end
    dec_rs2 = 0;
  endtask

  task automatic test_starvation();
    @(negedge clk);
    idle_inputs();
    wb_valid = 1; wb_rd = 3; wb_data = 32'h55; wb_mode = 3'b001;
    lu_res_valid = 1; lu_res_rd = 9; lu_res_data = 32'hBEEF; lu_res_mode = 3'b010;
    #1;
    checks++; if (rf_we3 !== 3'b001 || rf_a3 !== 5'd3 || rf_wd3 !== 32'h55) begin errors++; $display("FAIL wb_wins got=%b/%0d/%h exp=001/3/55", rf_we3, rf_a3, rf_wd3); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      lu_res_valid = 0;
      #1;
      if (k == 1) begin
        checks++; if (lu_res_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", lu_res_ready); end
      end
      if (k == 8) begin
        checks++; if (force_bubble !== 1'b0) begin errors++; $display("FAIL bubble_early got=%b exp=0", force_bubble); end
      end
    end
    @(negedge clk);
    #1;
    checks++; if (force_bubble !== 1'b1) begin errors++; $display("FAIL bubble_assert got=%b exp=1", force_bubble); end
    wb_valid = 0;
    #1;
    checks++; if (rf_we3 !== 3'b010 || rf_a3 !== 5'd9 || rf_wd3 !== 32'hBEEF) begin errors++; $display("FAIL starved_drain got=%b/%0d/%h exp=010/9/beef", rf_we3, rf_a3, rf_wd3); end
    checks++; if (force_bubble !== 1'b1 || lu_res_ready !== 1'b1) begin errors++; $display("FAIL drain_cycle_bubble_ready got=%b%b exp=11", force_bubble, lu_res_ready); end
    @(negedge clk);
    #1;
    checks++; if (force_bubble !== 1'b0 || rf_we3 !== 3'b000) begin errors++; $display("FAIL bubble_release got=%b/%b exp=0/000", force_bubble, rf_we3); end
    // Counter must restart from zero: 7 blocked cycles must not raise the bubble.
    wb_valid = 1; lu_res_valid = 1; lu_res_rd = 2; lu_res_mode = 3'b001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      lu_res_valid = 0;
    end
    #1;
    checks++; if (force_bubble !== 1'b0) begin errors++; $display("FAIL counter_restart got=%b exp=0", force_bubble); end
    wb_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle_inputs();
    wb_valid = 1; wb_rd = 1; wb_mode = 3'b001; wb_data = 32'h99;
    lu_res_valid = 1; lu_res_rd = 10; lu_res_data = 32'h1111; lu_res_mode = 3'b001;
    @(negedge clk);
    wb_valid = 0;
    lu_res_rd = 11; lu_res_data = 32'h2222; lu_res_mode = 3'b111;
    #1;
    checks++; if (lu_res_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", lu_res_ready); end
    checks++; if (rf_we3 !== 3'b001 || rf_a3 !== 5'd10 || rf_wd3 !== 32'h1111) begin errors++; $display("FAIL b2b_first got=%b/%0d/%h exp=001/10/1111", rf_we3, rf_a3, rf_wd3); end
    @(negedge clk);
    lu_res_valid = 0;
    wb_valid = 1; wb_rd = 4; wb_mode = 3'b011; wb_data = 32'h33;
    #1;
    checks++; if (rf_we3 !== 3'b011 || rf_a3 !== 5'd4 || lu_res_ready !== 1'b0) begin errors++; $display("FAIL b2b_held got=%b/%0d/%b exp=011/4/0", rf_we3, rf_a3, lu_res_ready); end
    @(negedge clk);
    wb_valid = 0;
    #1;
    checks++; if (rf_we3 !== 3'b111 || rf_a3 !== 5'd11 || rf_wd3 !== 32'h2222) begin errors++; $display("FAIL b2b_second got=%b/%0d/%h exp=111/11/2222", rf_we3, rf_a3, rf_wd3); end
    @(negedge clk);
    #1;
    checks++; if (rf_we3 !== 3'b000) begin errors++; $display("FAIL b2b_empty got=%b exp=000", rf_we3); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    idle_inputs();
    wb_valid = 1; wb_rd = 0; wb_mode = 3'b001; wb_data = 32'h77;
    lu_issue_valid = 1; lu_issue_rd = 0;
    #1;
    checks++; if (rf_we3 !== 3'b000) begin errors++; $display("FAIL wb_x0 got=%b exp=000", rf_we3); end
    wb_rd = 6; wb_mode = 3'b100;
    #1;
    checks++; if (rf_we3 !== 3'b000) begin errors++; $display("FAIL bad_mode got=%b exp=000", rf_we3); end
    @(negedge clk);
    lu_issue_valid = 0; wb_valid = 0;
    #1;
    checks++; if (dec_stall !== 1'b0) begin errors++; $display("FAIL x0_no_pending got=%b exp=0", dec_stall); end
    lu_res_valid = 1; lu_res_rd = 13; lu_res_data = 32'hD; lu_res_mode = 3'b001;
    @(negedge clk);
    lu_res_valid = 0;
    wb_valid = 1; wb_rd = 0; wb_mode = 3'b001;
    #1;
    checks++; if (rf_we3 !== 3'b000 || lu_res_ready !== 1'b0) begin errors++; $display("FAIL x0_takes_slot got=%b/%b exp=000/0", rf_we3, lu_res_ready); end
    @(negedge clk);
    wb_valid = 0;
    #1;
    checks++; if (rf_we3 !== 3'b001 || rf_a3 !== 5'd13) begin errors++; $display("FAIL x0_then_drain got=%b/%0d exp=001/13", rf_we3, rf_a3); end
    lu_res_valid = 1; lu_res_rd = 0; lu_res_data = 32'hF; lu_res_mode = 3'b001;
    @(negedge clk);
    lu_res_valid = 0;
    #1;
    checks++; if (rf_we3 !== 3'b000 || rf_a3 !== 5'd0) begin errors++; $display("FAIL drain_x0 got=%b/%0d exp=000/0", rf_we3, rf_a3); end
    @(negedge clk);
    wb_valid = 1; wb_rd = 8; wb_mode = 3'b001;
    #1;
    checks++; if (lu_res_ready !== 1'b1) begin errors++; $display("FAIL drain_x0_done got=%b exp=1", lu_res_ready); end
    wb_valid = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle_inputs();
    lu_issue_valid = 1; lu_issue_rd = 9;
    @(negedge clk);
    lu_issue_valid = 0; dec_rs1 = 9;
    wb_valid = 1; wb_rd = 1; wb_mode = 3'b001;
    lu_res_valid = 1; lu_res_rd = 20; lu_res_data = 32'h20; lu_res_mode = 3'b001;
    @(negedge clk);
    lu_res_valid = 0;
    #1;
    checks++; if (dec_stall !== 1'b1 || lu_res_ready !== 1'b0) begin errors++; $display("FAIL pre_reset got=%b/%b exp=1/0", dec_stall, lu_res_ready); end
    rst_n = 0; wb_valid = 0;
    #1;
    checks++; if (rf_we3 !== 3'b000 || dec_stall !== 1'b0 || lu_res_ready !== 1'b1) begin errors++; $display("FAIL async_reset got=%b/%b/%b exp=000/0/1", rf_we3, dec_stall, lu_res_ready); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    checks++; if (rf_we3 !== 3'b000 || dec_stall !== 1'b0 || force_bubble !== 1'b0) begin errors++; $display("FAIL post_reset got=%b/%b/%b exp=000/0/0", rf_we3, dec_stall, force_bubble); end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_scoreboard();
    test_starvation();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
